// File: rtl/ams_int_gen_if.sv
// Raster interrupt generator bus: CRTC sync inputs, register-block pulses,
// raster-line compare setup, and the interrupt/counter outputs.
interface ams_int_gen_if #(
   parameter int CNT_W = 6,
   parameter int PRI_W = 8
);
   logic             HSYNC;
   logic             VSYNC;
   logic             IRQ_RESET;
   logic             INT_ACK;
   logic             PRI_EN;
   logic [PRI_W-1:0] PRI_LINE;
   logic             INT_n;
   logic [CNT_W-1:0] HCNT;
   logic [PRI_W-1:0] LINE;

   modport master (
      output HSYNC, VSYNC, IRQ_RESET, INT_ACK, PRI_EN, PRI_LINE,
      input  INT_n, HCNT, LINE
   );

   modport slave (
      input  HSYNC, VSYNC, IRQ_RESET, INT_ACK, PRI_EN, PRI_LINE,
      output INT_n, HCNT, LINE
   );
endinterface

// File: rtl/ams_int_gen.sv
// Raster interrupt generator: periodic HSYNC-count interrupt with VSYNC
// resynchronisation, Z80 acknowledge handling and a raster-line compare mode.
module ams_int_gen #(
   parameter int LINES_PER_INT = 52,
   parameter int CNT_W         = 6,
   parameter int VSYNC_DELAY   = 2,
   parameter int PRI_W         = 8
) (
   input  logic         CLK_n,
   input  logic         RESET,
   ams_int_gen_if.slave bus
);
   localparam int                VCNT_W = $clog2(VSYNC_DELAY + 1);
   localparam logic [CNT_W-1:0]  WRAP   = CNT_W'(LINES_PER_INT);
   localparam logic [VCNT_W-1:0] VLOAD  = VCNT_W'(VSYNC_DELAY);

   logic              h1, h2, v1, v2;
   logic              hs_fall, vs_rise, resync;
   logic              pend, pend_d, set_req;
   logic [CNT_W-1:0]  hcnt, hcnt_d, hcnt_inc;
   logic [PRI_W-1:0]  line, line_d;
   logic [VCNT_W-1:0] vcnt, vcnt_d;

   assign hs_fall = h2 & ~h1;
   assign vs_rise = v1 & ~v2;
   // A VSYNC rise in the same cycle reloads VCNT, so no 1->0 transition occurs.
   assign resync  = hs_fall & ~vs_rise & (vcnt == VCNT_W'(1));

   assign bus.INT_n = ~pend;
   assign bus.HCNT  = hcnt;
   assign bus.LINE  = line;

   // Next-state logic: counters first, then acknowledge, then IRQ_RESET on top.
   always_comb begin
      hcnt_inc = hcnt + CNT_W'(1);
      hcnt_d   = hcnt;
      line_d   = line;
      vcnt_d   = vcnt;
      set_req  = 1'b0;

      if (vs_rise) begin
         vcnt_d = VLOAD;
         line_d = '0;
      end else if (hs_fall) begin
         if (vcnt != '0)
            vcnt_d = vcnt - VCNT_W'(1);
         if (line != '1)
            line_d = line + PRI_W'(1);
      end

      if (resync) begin
         hcnt_d  = '0;
         set_req = hcnt[CNT_W-1] & ~bus.PRI_EN;
      end else if (hs_fall) begin
         if (hcnt_inc == WRAP) begin
            hcnt_d  = '0;
            set_req = ~bus.PRI_EN;
         end else begin
            hcnt_d = hcnt_inc;
         end
      end

      if (hs_fall && bus.PRI_EN && (line == bus.PRI_LINE))
         set_req = 1'b1;

      // A request raised this cycle beats a coincident acknowledge.
      pend_d = set_req | (pend & ~bus.INT_ACK);
      if (bus.INT_ACK)
         hcnt_d[CNT_W-1] = 1'b0;

      if (bus.IRQ_RESET) begin
         hcnt_d = '0;
         pend_d = 1'b0;
      end
   end

   // Sync edge-detect pipeline and counter/request state registers.
   always_ff @(posedge CLK_n) begin
      if (RESET) begin
         h1   <= 1'b0;
         h2   <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         pend <= 1'b0;
         hcnt <= '0;
         line <= '0;
         vcnt <= '0;
      end else begin
         h1   <= bus.HSYNC;
         h2   <= h1;
         v1   <= bus.VSYNC;
         v2   <= v1;
         pend <= pend_d;
         hcnt <= hcnt_d;
         line <= line_d;
         vcnt <= vcnt_d;
      end
   end
endmodule

// File: tb/tb_ams_int_gen.sv
// Self-checking bench for ams_int_gen: a default instance and a
// LINES_PER_INT=10 / CNT_W=4 instance share the CRTC sync stimulus.
module tb_ams_int_gen;
   typedef struct {
      string name;
      bit    on_b;
      bit    int_n;
      int    hcnt;
      int    line;
   } exp_t;

   typedef struct {
      string name;
      int    pulses;
      bit    ack;
      bit    irq;
      bit    int_n;
      int    hcnt;
      int    line;
   } vec_t;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       hsync    = 1'b0;
   logic       vsync    = 1'b0;
   logic       pri_en   = 1'b0;
   logic [7:0] pri_line = 8'd0;
   logic       ack_a    = 1'b0;
   logic       irq_a    = 1'b0;
   logic       ack_b    = 1'b0;
   logic       irq_b    = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vt[8];

   ams_int_gen_if #(.CNT_W(6), .PRI_W(8)) bus_a ();
   ams_int_gen_if #(.CNT_W(4), .PRI_W(8)) bus_b ();

   assign bus_a.HSYNC     = hsync;
   assign bus_a.VSYNC     = vsync;
   assign bus_a.IRQ_RESET = irq_a;
   assign bus_a.INT_ACK   = ack_a;
   assign bus_a.PRI_EN    = pri_en;
   assign bus_a.PRI_LINE  = pri_line;
   assign bus_b.HSYNC     = hsync;
   assign bus_b.VSYNC     = vsync;
   assign bus_b.IRQ_RESET = irq_b;
   assign bus_b.INT_ACK   = ack_b;
   assign bus_b.PRI_EN    = 1'b0;
   assign bus_b.PRI_LINE  = 8'd0;

   ams_int_gen #(.LINES_PER_INT(52), .CNT_W(6), .VSYNC_DELAY(2), .PRI_W(8)) dut_a (
      .CLK_n (clk),
      .RESET (rst),
      .bus   (bus_a)
   );

   ams_int_gen #(.LINES_PER_INT(10), .CNT_W(4), .VSYNC_DELAY(2), .PRI_W(8)) dut_b (
      .CLK_n (clk),
      .RESET (rst),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic void expect_out(input string name, input bit on_b,
                                      input bit int_n, input int hcnt, input int line);
      exp_t e;
      e.name  = name;
      e.on_b  = on_b;
      e.int_n = int_n;
      e.hcnt  = hcnt;
      e.line  = line;
      sb.push_back(e);
   endfunction

   // Drain the scoreboard against the current DUT outputs.
   task automatic compare_out();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.on_b) begin
            check_val({e.name, ".INT_n"}, int'(bus_b.INT_n), int'(e.int_n));
            check_val({e.name, ".HCNT"},  int'(bus_b.HCNT),  e.hcnt);
            check_val({e.name, ".LINE"},  int'(bus_b.LINE),  e.line);
         end else begin
            check_val({e.name, ".INT_n"}, int'(bus_a.INT_n), int'(e.int_n));
            check_val({e.name, ".HCNT"},  int'(bus_a.HCNT),  e.hcnt);
            check_val({e.name, ".LINE"},  int'(bus_a.LINE),  e.line);
         end
      end
   endtask

   // One HSYNC pulse; side pulses coincide with the hs_fall cycle, state updated on return.
   task automatic hs_pulse(input bit a_ack, input bit a_irq, input bit b_ack);
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      tick();
      ack_a = a_ack;
      irq_a = a_irq;
      ack_b = b_ack;
      tick();
      ack_a = 1'b0;
      irq_a = 1'b0;
      ack_b = 1'b0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++)
         hs_pulse(1'b0, 1'b0, 1'b0);
   endtask

   task automatic vsync_pulse();
      vsync = 1'b1;
      tick();
      tick();
      vsync = 1'b0;
   endtask

   task automatic run_vec(input int i);
      pulses(vt[i].pulses);
      if (vt[i].ack || vt[i].irq) begin
         ack_a = vt[i].ack;
         irq_a = vt[i].irq;
         tick();
         ack_a = 1'b0;
         irq_a = 1'b0;
      end
      expect_out(vt[i].name, 1'b0, vt[i].int_n, vt[i].hcnt, vt[i].line);
      compare_out();
   endtask

   initial begin
      int falls;
      int fall_idx;
      bit prev;

      vt[0] = '{"per_31",   30, 1'b0, 1'b0, 1'b1, 31,  31};
      vt[1] = '{"per_51",   20, 1'b0, 1'b0, 1'b1, 51,  51};
      vt[2] = '{"hold_low", 40, 1'b0, 1'b0, 1'b0, 40,  92};
      vt[3] = '{"ack_40",    0, 1'b1, 1'b0, 1'b1,  8,  92};
      vt[4] = '{"per_13",    5, 1'b0, 1'b0, 1'b1, 13,  97};
      vt[5] = '{"irq_clr",   0, 1'b0, 1'b1, 1'b1,  0,  97};
      vt[6] = '{"wrap2",    52, 1'b0, 1'b0, 1'b0,  0, 149};
      vt[7] = '{"irq_pend",  0, 1'b0, 1'b1, 1'b1,  0, 149};

      // Reset held with HSYNC toggling.
      for (int i = 0; i < 3; i++) begin
         hsync = ~hsync;
         tick();
         expect_out("reset", 1'b0, 1'b1, 0, 0);
         compare_out();
      end
      rst   = 1'b0;
      hsync = 1'b0;
      tick();
      hs_pulse(1'b0, 1'b0, 1'b0);
      expect_out("first_line", 1'b0, 1'b1, 1, 1);
      compare_out();

      // Periodic mode.
      run_vec(0);
      run_vec(1);
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      tick();
      expect_out("fall52_pre", 1'b0, 1'b1, 51, 51);
      compare_out();
      tick();
      expect_out("fall52_post", 1'b0, 1'b0, 0, 52);
      compare_out();
      for (int i = 2; i < 8; i++)
         run_vec(i);

      // VSYNC resync with the half-period bit set.
      pulses(35);
      expect_out("pre_vs_35", 1'b0, 1'b1, 35, 184);
      compare_out();
      vsync_pulse();
      expect_out("vs_line0", 1'b0, 1'b1, 35, 0);
      compare_out();
      hs_pulse(1'b0, 1'b0, 1'b0);
      expect_out("vs_fall1", 1'b0, 1'b1, 36, 1);
      compare_out();
      hs_pulse(1'b0, 1'b0, 1'b0);
      expect_out("resync_hi", 1'b0, 1'b0, 0, 2);
      compare_out();
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;

      // VSYNC resync with the half-period bit clear.
      pulses(10);
      vsync_pulse();
      hs_pulse(1'b0, 1'b0, 1'b0);
      expect_out("vs2_fall1", 1'b0, 1'b1, 11, 1);
      compare_out();
      hs_pulse(1'b0, 1'b0, 1'b0);
      expect_out("resync_lo", 1'b0, 1'b1, 0, 2);
      compare_out();

      // IRQ_RESET coincident with hs_fall while pending.
      pulses(72);
      expect_out("pend_20", 1'b0, 1'b0, 20, 74);
      compare_out();
      hs_pulse(1'b0, 1'b1, 1'b0);
      expect_out("irq_hsfall", 1'b0, 1'b1, 0, 75);
      compare_out();

      // Acknowledge coincident with the wrapping hs_fall.
      pulses(51);
      hs_pulse(1'b1, 1'b0, 1'b0);
      expect_out("ack_wrap", 1'b0, 1'b0, 0, 127);
      compare_out();
      ack_a = 1'b1;
      tick();
      ack_a = 1'b0;

      // Raster-line compare mode.
      pri_en   = 1'b1;
      pri_line = 8'd100;
      vsync_pulse();
      falls    = 0;
      fall_idx = 0;
      prev     = bus_a.INT_n;
      for (int i = 1; i <= 120; i++) begin
         hs_pulse(1'b0, 1'b0, 1'b0);
         if (prev && !bus_a.INT_n) begin
            falls++;
            fall_idx = i;
         end
         prev = bus_a.INT_n;
      end
      check_val("pri_falls", falls, 1);
      check_val("pri_fall_line", fall_idx, 101);
      expect_out("pri_end", 1'b0, 1'b0, 14, 120);
      compare_out();
      ack_a = 1'b1;
      tick();
      ack_a  = 1'b0;
      pri_en = 1'b0;

      // Small instance: acknowledge clears bit 3, then collision at the wrap.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      expect_out("b_reset", 1'b1, 1'b1, 0, 0);
      compare_out();
      pulses(9);
      expect_out("b_cnt9", 1'b1, 1'b1, 9, 9);
      compare_out();
      ack_b = 1'b1;
      tick();
      ack_b = 1'b0;
      expect_out("b_ack9", 1'b1, 1'b1, 1, 9);
      compare_out();
      pulses(8);
      hs_pulse(1'b0, 1'b0, 1'b1);
      expect_out("b_ack_wrap", 1'b1, 1'b0, 0, 18);
      compare_out();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
